// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake
// into a prefetch queue. Define FETCH_STATS_EN to add fetch/flush counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus8,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        PCSrc,
   input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] fetch_count,
   output logic [15:0] flush_count
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

   state_t        state, state_next;
   logic [31:0]   fetch_pc, discard_addr;
   logic [31:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_next;
   logic          ack_take, push, pop;

   // Redirect wins over both push and pop; an ack outside IDLE is always consumed.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      ack_take   = imem_ack && (state != IDLE);
      push       = ack_take && (state == WAIT) && !PCSrc;
      pop        = instr_valid && instr_ready && !PCSrc;
      count_next = count;
      if (PCSrc)
         count_next = '0;
      else if (push && !pop)
         count_next = count + CW'(1);
      else if (pop && !push)
         count_next = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:
            if (!PCSrc && count < FULL)
               state_next = WAIT;
         WAIT:
            if (PCSrc)
               state_next = imem_ack ? WAIT : DISCARD;
            else if (imem_ack)
               state_next = (count_next < FULL) ? WAIT : IDLE;
         DISCARD:
            if (imem_ack)
               state_next = (count_next < FULL) ? WAIT : IDLE;
         default:
            state_next = IDLE;
      endcase
   end

   // While discarding, the abandoned address stays on the bus until its ack.
   always_comb begin
      imem_req  = (state != IDLE);
      imem_addr = (state == DISCARD) ? discard_addr : fetch_pc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc     <= RESET_PC;
         discard_addr <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
      end else begin
         count <= count_next;
         if (state == WAIT && PCSrc && !imem_ack)
            discard_addr <= fetch_pc;
         if (PCSrc) begin
            fetch_pc <= redirect_pc & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + 32'd4;
               wr_ptr   <= wr_ptr + PW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // NOTE: queue storage has no reset; occupancy is tracked by count, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= imem_addr;
         data_q[wr_ptr] <= imem_rdata;
      end
   end

   always_comb begin
      instr_valid = (count != '0);
      Instr       = '0;
      PC          = '0;
      if (instr_valid) begin
         Instr = data_q[rd_ptr];
         PC    = addr_q[rd_ptr];
      end
      PCPlus8 = PC + 32'd8;
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= '0;
         flush_count <= '0;
      end else begin
         if (ack_take)
            fetch_count <= fetch_count + 32'd1;
         if (PCSrc)
            flush_count <= flush_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table plus a delivery scoreboard
// and hand-written redirect/discard/reset sequences against a latency-programmable memory.
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk, reset;
   logic        imem_req, imem_ack, instr_valid, instr_ready, PCSrc;
   logic [31:0] imem_addr, imem_rdata, Instr, PC, PCPlus8, redirect_pc;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [15:0] flush_count;
`endif

   fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .Instr(Instr), .PC(PC), .PCPlus8(PCPlus8), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .PCSrc(PCSrc), .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
      , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: acks once the request has been held for lat cycles; late_ack injects a stray ack.
   int   lat;
   int   wait_cnt;
   logic late_ack;
   assign imem_ack   = (imem_req && wait_cnt >= lat) || late_ack;
   assign imem_rdata = late_ack ? 32'hDEAD_BEEF : (imem_addr ^ KEY);
   always @(posedge clk) begin
      if (!imem_req || imem_ack) wait_cnt <= 0;
      else                       wait_cnt <= wait_cnt + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every accepted instruction must be the next one the bench expects.
   always @(negedge clk) begin
      if (!reset && instr_valid && instr_ready && !PCSrc) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got PC %h expected nothing at %0t", PC, $time);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            check("sb_pc", PC, e);
            check("sb_instr", Instr, e ^ KEY);
            check("sb_pcplus8", PCPlus8, e + 32'd8);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset    = 1'b1;
      PCSrc    = 1'b0;
      late_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_valid(input int max, input string name);
      int n = 0;
      while (!instr_valid && n < max) begin
         next_cycle();
         n++;
      end
      check(name, {31'b0, instr_valid}, 32'd1);
   endtask

   typedef struct {
      logic        ready;
      logic        pcsrc;
      logic [31:0] rpc;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_req;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[22];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; instr_ready = 1'b1; PCSrc = 1'b0; redirect_pc = '0;
      late_ack = 1'b0; lat = 0;

      // Zero-wait memory: startup, stall until full, release, then redirect while full.
      vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b1, 32'h4};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h8};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'hC};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h10};
      for (int i = 6; i <= 10; i++)
         vecs[i] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hC,   1'b0, 32'h14};
      vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h14};
      vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h14};
      vecs[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h14};
      vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h18};
      vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h1C};
      vecs[16] = '{1'b0, 1'b1, 32'h103, 1'b1, 32'h18,  1'b0, 32'h20};
      vecs[17] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100};
      vecs[18] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100};
      vecs[19] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h104};
      vecs[20] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h108};
      vecs[21] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h10C};

      reset_dut();
      for (int i = 0; i < 22; i++) begin
         instr_ready = vecs[i].ready;
         PCSrc       = vecs[i].pcsrc;
         redirect_pc = vecs[i].rpc;
         if (vecs[i].exp_valid && vecs[i].ready && !vecs[i].pcsrc)
            sb.push_back(vecs[i].exp_pc);
         check($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
         check($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
         check($sformatf("vec%0d_instr", i), Instr,
               vecs[i].exp_valid ? (vecs[i].exp_pc ^ KEY) : 32'h0);
         check($sformatf("vec%0d_pcplus8", i), PCPlus8, vecs[i].exp_pc + 32'd8);
         check($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
         if (vecs[i].exp_req)
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
         next_cycle();
      end
      instr_ready = 1'b0;
      check("table_sb_drained", 32'(sb.size()), 32'd0);

      // Redirect one cycle after a slow request: old address held, its data dropped.
      lat = 3; instr_ready = 1'b1;
      reset_dut();
      PCSrc = 1'b1; redirect_pc = 32'h10;
      next_cycle();
      PCSrc = 1'b0;
      next_cycle();
      check("disc_req0_addr", imem_addr, 32'h10);
      next_cycle();
      PCSrc = 1'b1; redirect_pc = 32'h40;
      check("disc_req1", {31'b0, imem_req}, 32'd1);
      next_cycle();
      PCSrc = 1'b0;
      check("disc_hold_req", {31'b0, imem_req}, 32'd1);
      check("disc_hold_addr", imem_addr, 32'h10);
      next_cycle();
      check("disc_ack_addr", imem_addr, 32'h10);
      next_cycle();
      check("disc_new_req", {31'b0, imem_req}, 32'd1);
      check("disc_new_addr", imem_addr, 32'h40);
      check("disc_no_valid", {31'b0, instr_valid}, 32'd0);
      sb.push_back(32'h40);
      wait_valid(10, "disc_valid_timeout");
      next_cycle();
      instr_ready = 1'b0;
      check("disc_sb_drained", 32'(sb.size()), 32'd0);

      // Redirect coinciding with the ack for 0x8: no discard wait, next request at target.
      lat = 0; instr_ready = 1'b1;
      reset_dut();
      sb.push_back(32'h0);
      next_cycle();
      next_cycle();
      next_cycle();
      PCSrc = 1'b1; redirect_pc = 32'h200;
      check("coinc_addr", imem_addr, 32'h8);
      check("coinc_ack", {31'b0, imem_ack}, 32'd1);
      next_cycle();
      PCSrc = 1'b0;
      check("coinc_flushed", {31'b0, instr_valid}, 32'd0);
      check("coinc_req", {31'b0, imem_req}, 32'd1);
      check("coinc_addr_target", imem_addr, 32'h200);
      sb.push_back(32'h200);
      next_cycle();
      check("coinc_pc", PC, 32'h200);
      next_cycle();
      instr_ready = 1'b0;
      check("coinc_sb_drained", 32'(sb.size()), 32'd0);

      // Fetch address wraps from the top of memory; low target bits ignored.
      instr_ready = 1'b1;
      reset_dut();
      PCSrc = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      sb.push_back(32'hFFFF_FFFC);
      sb.push_back(32'h0);
      sb.push_back(32'h4);
      next_cycle();
      PCSrc = 1'b0;
      next_cycle();
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      next_cycle();
      check("wrap_pcplus8", PCPlus8, 32'h4);
      next_cycle();
      next_cycle();
      next_cycle();
      instr_ready = 1'b0;
      check("wrap_sb_drained", 32'(sb.size()), 32'd0);

      // Reset while a request is outstanding, then a stray ack while idle.
      lat = 3; instr_ready = 1'b1;
      reset_dut();
      PCSrc = 1'b1; redirect_pc = 32'h0;
      next_cycle();
      PCSrc = 1'b0;
      next_cycle();
      next_cycle();
      check("rst_req_out", {31'b0, imem_req}, 32'd1);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0; late_ack = 1'b1;
      check("rst_req_low", {31'b0, imem_req}, 32'd0);
      check("rst_valid_low", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_STATS_EN
      check("rst_fetch_count", fetch_count, 32'd0);
      check("rst_flush_count", {16'b0, flush_count}, 32'd0);
`endif
      next_cycle();
      late_ack = 1'b0;
      check("rst_late_ack_ignored", {31'b0, instr_valid}, 32'd0);
      check("rst_restart_req", {31'b0, imem_req}, 32'd1);
      check("rst_restart_addr", imem_addr, 32'h0);
`ifdef FETCH_STATS_EN
      check("rst_fetch_count_late", fetch_count, 32'd0);
`endif
      sb.push_back(32'h0);
      wait_valid(10, "rst_valid_timeout");
      next_cycle();
      instr_ready = 1'b0;
      check("rst_sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
